// File: rtl/cpu_edu_pkg.sv
// Shared constants and command payload for the register-file arbiter slice.
package cpu_edu_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned REQ_CPU = 0;
  localparam int unsigned REQ_DBG = 1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_cmd_t;

endpackage

// File: rtl/regfile_arbiter_if.sv
// Requester handshake plus register-file port bundle around regfile_arbiter.
interface regfile_arbiter_if;
  import cpu_edu_pkg::*;

  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              lock0, lock1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] rf_regname1, rf_regname2;
  logic [DATA_W-1:0] rf_in;
  logic              rf_rw;
  logic [DATA_W-1:0] rf_out1;

  // Arbiter side
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
    input  rf_out1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata,
    output rf_regname1, rf_regname2, rf_in, rf_rw
  );

  // Requesters plus register file side
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
    output rf_out1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata,
    input  rf_regname1, rf_regname2, rf_in, rf_rw
  );

endinterface

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin selector with an optional sticky owner.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  input  logic       owner,
  input  logic       owner_valid,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (owner_valid && req[owner]) begin
      gnt[owner] = 1'b1;
    end else if (&req) begin
      gnt[rr_ptr] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one 16x8 register file between CPU and debug port.
// Optional grant locking with a hold limit is enabled by defining ARB_LOCK_EN.
module regfile_arbiter
  import cpu_edu_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input logic             clk,
  input logic             rst,
  regfile_arbiter_if.slave bus
);

  logic [1:0]        req_c;
  logic [1:0]        pick_gnt_c;
  logic [1:0]        gnt_c;
  logic [1:0]        xfer_c;
  logic              any_c;
  logic              win_c;
  logic              pick_owner_c;
  logic              pick_owner_valid_c;
  logic              rr_ptr;
  logic [1:0]        rvalid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  req_cmd_t          cmd_c [2];
  req_cmd_t          sel_c;

  assign req_c = {bus.req1, bus.req0};

  always_comb begin
    cmd_c[0] = '{we: bus.we0, addr: bus.addr0, wdata: bus.wdata0};
    cmd_c[1] = '{we: bus.we1, addr: bus.addr1, wdata: bus.wdata1};
  end

  rr_pick2 u_pick (
    .req         (req_c),
    .rr_ptr      (rr_ptr),
    .owner       (pick_owner_c),
    .owner_valid (pick_owner_valid_c),
    .gnt         (pick_gnt_c)
  );

  // Reset forces an idle port so nothing reaches the register file
  assign gnt_c  = rst ? 2'b00 : pick_gnt_c;
  assign xfer_c = gnt_c & req_c;
  assign any_c  = |xfer_c;
  assign win_c  = xfer_c[1];
  assign sel_c  = cmd_c[win_c];

  assign bus.gnt0        = gnt_c[0];
  assign bus.gnt1        = gnt_c[1];
  assign bus.rf_regname1 = any_c ? sel_c.addr : addr_q;
  assign bus.rf_regname2 = bus.rf_regname1;
  assign bus.rf_in       = any_c ? sel_c.wdata : wdata_q;
  assign bus.rf_rw       = any_c & sel_c.we;

  // A reset arriving while read data is due cancels it immediately
  assign bus.rvalid0 = rvalid_q[0] & ~rst;
  assign bus.rvalid1 = rvalid_q[1] & ~rst;
  assign bus.rdata   = bus.rf_out1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= 1'b0;
      rvalid_q <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      rvalid_q <= xfer_c & {2{~sel_c.we}};
      if (any_c) begin
        rr_ptr  <= ~win_c;
        addr_q  <= sel_c.addr;
        wdata_q <= sel_c.wdata;
      end
    end
  end

`ifdef ARB_LOCK_EN
  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

  logic [1:0]       lock_c;
  logic             lock_valid;
  logic             lock_owner;
  logic [CNT_W-1:0] hold_cnt;
  logic             held_c;
  logic             expired_c;

  assign lock_c    = {bus.lock1, bus.lock0};
  assign held_c    = lock_valid && lock_c[lock_owner] && req_c[lock_owner];
  assign expired_c = lock_valid && (hold_cnt >= CNT_W'(MAX_HOLD));

  // On expiry the other requester gets one turn of forced priority
  assign pick_owner_c       = expired_c ? ~lock_owner : lock_owner;
  assign pick_owner_valid_c = expired_c | held_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_valid <= 1'b0;
      lock_owner <= 1'b0;
      hold_cnt   <= '0;
    end else if (expired_c) begin
      lock_valid <= 1'b0;
      hold_cnt   <= '0;
    end else if (any_c && lock_c[win_c]) begin
      if (held_c && (lock_owner == win_c)) begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end else begin
        lock_owner <= win_c;
        lock_valid <= 1'b1;
        hold_cnt   <= CNT_W'(1);
      end
    end else if (lock_valid) begin
      lock_valid <= 1'b0;
      hold_cnt   <= '0;
    end
  end
`else
  logic unused_lock;

  assign pick_owner_c       = 1'b0;
  assign pick_owner_valid_c = 1'b0;
  assign unused_lock        = ^{bus.lock0, bus.lock1, 32'(MAX_HOLD)};
`endif

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Shares the single 16x8 register file between two requesters: requester 0 is the CPU control unit and requester 1 is the debug/loader port.
- Round-robin arbitration grants at most one access per cycle. The winner's command is muxed onto the register-file port, and read data returns one cycle later, tagged to the winner.
- Sits between the requesters and the register file in processing_unit. The register file is unchanged: reads are registered, and a write updates `r[regname1]` on the same edge.

Parameters:
- DATA_W, 8, register data width
- ADDR_W, 4, register index width (16 registers)
- MAX_HOLD, 8, maximum consecutive locked grants to one requester (used only with ARB_LOCK_EN)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0, req1  in  1  access request; held, with command stable, until the handshake completes
- we0, we1  in  1  1 = write, 0 = read
- addr0, addr1  in  ADDR_W  register index
- wdata0, wdata1  in  DATA_W  write data
- lock0, lock1  in  1  keep grant across consecutive accesses (ARB_LOCK_EN only; ignored otherwise)
- gnt0, gnt1  out  1  combinational grant; transfer occurs on an edge where reqN and gntN are both high
- rvalid0, rvalid1  out  1  read data valid for that requester, one cycle after a read transfer
- rdata  out  DATA_W  read data, shared bus, qualified by rvalidN
- rf_regname1  out  ADDR_W  register-file address (read/write)
- rf_regname2  out  ADDR_W  tied to rf_regname1
- rf_in  out  DATA_W  register-file write data
- rf_rw  out  1  register-file write enable
- rf_out1  in  DATA_W  register-file registered read data

Behaviour:
- Reset values:
  - rr_ptr = 0, meaning requester 0 has priority first.
  - rvalid0 = rvalid1 = 0; rdata = rf_out1 (don't-care while rvalid is low).
  - While rst is high: gnt0 = gnt1 = 0 and rf_rw = 0.
  - Lock owner is cleared and hold_cnt = 0.
- Arbitration (combinational, from registered state):
  - Only req0 high -> gnt0.
  - Only req1 high -> gnt1.
  - Both high -> grant the requester selected by rr_ptr.
  - Neither high -> no grant, rf_rw = 0.
- Grants are one-hot or zero, never both.
- rr_ptr update: after a transfer by requester N, rr_ptr = 1-N. No transfer -> rr_ptr unchanged.
- Datapath during the grant cycle:
  - rf_regname1 = addrN and rf_in = wdataN.
  - rf_rw = weN AND gntN.
  - When there is no grant, rf_regname1 holds its last value and rf_rw = 0.
- Read latency: a read transfer at edge E raises rvalidN for exactly the cycle after E, with rdata = rf_out1 (the value before any write at E).
- Throughput: back-to-back transfers every cycle. rvalid may be high in the same cycle as a new grant.
- Read-after-write: a write at edge E followed by a read of the same address at E+1 returns the new value. The arbiter inserts no hazard logic.
- Writes produce no rvalid.
- Requester rules:
  - A requester must not change we/addr/wdata while req is high without a grant.
  - Dropping req before a grant is allowed; the request is withdrawn.
- Reset mid-operation: a pending rvalid is cancelled. Accesses in flight are lost.

Optional Feature:
- Macro ARB_LOCK_EN.
- Defined:
  - A transfer by N with lockN = 1 makes N the owner. While the owner holds lock and req, it wins regardless of rr_ptr.
  - hold_cnt counts consecutive owner grants. On reaching MAX_HOLD, the next cycle grants the other requester if it is requesting, then clears ownership and hold_cnt.
  - Dropping lock, or a cycle with no owner request, clears ownership.
- Not defined: lock0/lock1 are ignored, and hold_cnt and owner logic are absent.

Decomposition:
- Shared package `cpu_edu_pkg`:
  - Constants DATA_W, ADDR_W and REQ_CPU = 0, REQ_DBG = 1.
  - Typedef for a requester command struct {we, addr, wdata}.
- One natural sub-module, `rr_pick2`: a combinational 2-way round-robin selector. It takes req[1:0], rr_ptr, and owner/owner_valid, and outputs a one-hot gnt.
- The top module holds rr_ptr, the rvalid pipeline, the muxing and the lock counter.

Test Plan:
- Reset then idle: rst high 2 cycles -> gnt = 00, rvalid = 00, rf_rw = 0 throughout. After release with no req, all stay 0.
- Single write/read: req0 write addr = 3, wdata = 0xA5; then req0 read addr = 3 -> gnt0 for 1 cycle each, rf_rw = 1 only in the write cycle. rvalid0 = 1 one cycle after the read grant with rdata = 0xA5.
- Contention: req0 and req1 both held continuously (reads of addr 1 and 2) -> grants alternate 0, 1, 0, 1 starting with 0 after reset. Each rvalid follows its grant by exactly 1 cycle.
- Read-after-write: req1 writes addr = 7 with 0x3C at edge E; req0 reads addr = 7 at E+1 -> rvalid0 at E+2 with rdata = 0x3C.
- Reset mid-operation: rst asserted in the cycle after a read transfer -> rvalid stays 0 and rr_ptr returns to 0.
- ARB_LOCK_EN: req0 with lock0 = 1 continuously, req1 continuously, MAX_HOLD = 4 -> 4 consecutive gnt0, then one gnt1, then gnt0 again. Without the macro, strict alternation.
